// File: rtl/select_controller_pkg.sv
// Shared types and constants for the select controller and its button debouncer.
package select_controller_pkg;

  typedef enum logic [1:0] {
    StReleased   = 2'd0,
    StPressChk   = 2'd1,
    StPressed    = 2'd2,
    StReleaseChk = 2'd3
  } db_state_e;

  localparam logic ModeManual = 1'b0;
  localparam logic ModeAuto   = 1'b1;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw pushbutton and debounces it; emits a one-cycle press pulse and the level.
module button_debouncer
  import select_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press,
  output logic lvl
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta, btn_s;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lvl_q, lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      state_q  <= StReleased;
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  // Counter only advances while a candidate edge is being qualified.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    press   = 1'b0;
    unique case (state_q)
      StReleased: begin
        cnt_d = '0;
        if (btn_s) state_d = StPressChk;
      end
      StPressChk: begin
        if (!btn_s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
          cnt_d   = '0;
          press   = 1'b1;
        end
      end
      StPressed: begin
        cnt_d = '0;
        if (!btn_s) state_d = StReleaseChk;
      end
      StReleaseChk: begin
        if (btn_s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StReleased;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
    lvl_d = (state_d == StPressed) || (state_d == StReleaseChk);
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/select_controller.sv
// Drives the data selector's SEL: toggled by debounced presses in manual mode,
// or on a fixed period in auto mode.
module select_controller
  import select_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 100000000,
  parameter logic        SEL_RESET       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic mode,
  output logic sel,
  output logic sel_chg,
  output logic btn_lvl
);

  localparam int unsigned PerW = $clog2(AUTO_PERIOD);
  localparam logic [PerW-1:0] PerMax = PerW'(AUTO_PERIOD - 1);

  logic            press;
  logic            mode_meta, mode_s;
  logic [PerW-1:0] per_q, per_d;
  logic            sel_q, sel_d;
  logic            sel_chg_q;
  logic            toggle;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .press(press),
    .lvl  (btn_lvl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= 1'b0;
      mode_s    <= 1'b0;
      per_q     <= '0;
      sel_q     <= SEL_RESET;
      sel_chg_q <= 1'b0;
    end else begin
      mode_meta <= mode;
      mode_s    <= mode_meta;
      per_q     <= per_d;
      sel_q     <= sel_d;
      sel_chg_q <= toggle;
    end
  end

  // Timer is held at zero in manual mode so auto mode always starts a full period.
  always_comb begin
    toggle = 1'b0;
    per_d  = '0;
    if (mode_s == ModeAuto) begin
      if (per_q == PerMax) begin
        toggle = 1'b1;
      end else begin
        per_d = per_q + PerW'(1);
      end
    end else begin
      toggle = press;
    end
    sel_d = sel_q ^ toggle;
  end

  assign sel     = sel_q;
  assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_select_controller.sv
// Directed and randomized checks of select_controller against a run-length behavioural model.
module tb_select_controller;

  localparam int unsigned Db = 4;
  localparam int unsigned Ap = 8;

  logic clk = 1'b0;
  logic rst_n, btn, mode;
  logic sel, sel_chg, btn_lvl;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: synchroniser images, debounced level with its disagreement run,
  // cycles spent in auto mode, and the expected outputs.
  bit b1, b2, mo1, mo2;
  bit m_lvl, m_sel, m_chg, prev_chg;
  int m_run, m_phase;
  int r;

  select_controller #(
    .DEBOUNCE_CYCLES(Db),
    .AUTO_PERIOD    (Ap),
    .SEL_RESET      (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .mode   (mode),
    .sel    (sel),
    .sel_chg(sel_chg),
    .btn_lvl(btn_lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    b1 = 0; b2 = 0; mo1 = 0; mo2 = 0;
    m_lvl = 0; m_sel = 0; m_chg = 0; prev_chg = 0;
    m_run = 0; m_phase = 0;
  endtask

  // A level change is accepted once the synced input has disagreed for Db+1 cycles.
  task automatic model_edge();
    bit bs, ms, pr, tg;
    bs = b2; ms = mo2; pr = 0; tg = 0;
    if (bs != m_lvl) begin
      m_run++;
      if (m_run == Db + 1) begin
        pr = bs;
        m_lvl = bs;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (ms) begin
      m_phase++;
      if (m_phase == Ap) begin
        tg = 1;
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
      tg = pr;
    end
    m_sel = m_sel ^ tg;
    m_chg = tg;
    b2 = b1; b1 = btn; mo2 = mo1; mo1 = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("sel", sel, m_sel);
    chk("sel_chg", sel_chg, m_chg);
    chk("btn_lvl", btn_lvl, m_lvl);
    chk("sel_chg_twice", sel_chg & prev_chg, 1'b0);
    prev_chg = sel_chg;
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_sel"}, sel, 1'b0);
    chk({tag, "_chg"}, sel_chg, 1'b0);
    chk({tag, "_lvl"}, btn_lvl, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; btn = 1'b0; mode = 1'b0;
    model_reset();

    // 1: async reset between edges
    #2;
    async_reset_check("rst0");
    repeat (2) tick();
    rst_n = 1'b1;

    // 2: clean press; SEL must flip exactly on edge 7
    btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("latency_sel", sel, logic'(i == 7));
      chk("latency_chg", sel_chg, logic'(i == 7));
    end
    repeat (13) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk("held_sel", sel, 1'b1);
    btn = 1'b1;
    repeat (20) tick();
    chk("second_press_sel", sel, 1'b0);
    btn = 1'b0;
    repeat (10) tick();

    // 3: bounce never qualifies
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; tick();
    btn = 1'b1; repeat (2) tick();
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bounce_lvl", btn_lvl, 1'b0);
      chk("bounce_sel", sel, 1'b0);
    end

    // 4: auto mode, press ignored for SEL
    mode = 1'b1;
    repeat (40) tick();
    btn = 1'b1; repeat (20) tick();
    chk("auto_lvl_held", btn_lvl, 1'b1);
    btn = 1'b0; repeat (20) tick();

    // 5: leave auto at per_cnt=5, then come back
    for (int i = 0; i < 20 && m_phase != 5; i++) tick();
    chk("phase_reached", logic'(m_phase == 5), 1'b1);
    mode = 1'b0;
    repeat (12) tick();
    mode = 1'b1;
    repeat (24) tick();

    // 6: reset while qualifying a press, button kept high
    mode = 1'b0;
    repeat (4) tick();
    btn = 1'b1;
    repeat (4) tick();
    #3;
    async_reset_check("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("rst_latency_sel", sel, logic'(i == 7));
    end
    btn = 1'b0;
    repeat (10) tick();

    // Randomized segments: held levels, short bounces, mode flips, occasional reset
    for (int seg = 0; seg < 120; seg++) begin
      r = int'($urandom_range(0, 29));
      if (r == 0) begin
        async_reset_check("rst_rand");
        tick();
        rst_n = 1'b1;
      end else if (r < 4) begin
        mode = ~mode;
      end
      btn = 1'($urandom_range(0, 1));
      if (r < 15) repeat ($urandom_range(1, 4)) tick();
      else repeat ($urandom_range(5, 14)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
